// File: rtl/up_seq_ctrl.sv
// up_seq_ctrl: APB-programmed pattern sequencer driving 8 pads.
// Ports: HCLK/HRESETn, APB slave (PADDR..PSLVERR), upio_in_i,
//   upio_out_o (pattern), upio_dir_o (1=out), int_o (done irq).
module up_seq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [7:0]                upio_in_i,
  output logic [7:0]                upio_out_o,
  output logic [7:0]                upio_dir_o,
  output logic                      int_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d, loop_q, loop_d;
  logic          ie_q, ie_d, done_q, done_d;
  logic          int_q;
  logic [15:0]   pre_q, pre_d, timer_q, timer_d;
  logic [7:0]    dir_q, dir_d, out_q, out_d;
  logic [7:0]    cap_q, cap_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, cnt_after;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          acc, wr, rd, unmapped;
  logic [2:0]    sel;
  logic          a_ctrl, a_pre, a_dir;
  logic          a_fifo, a_stat, a_cap;
  logic          full, empty, busy;
  logic          retire, pop, rot, flush;
  logic          push_req, push_ok;
  logic [AW-1:0] rptr_nx, wptr_nx;
  logic [7:0]    nxt_head;
  logic          unused_ok;

  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE;
  assign rd       = acc & ~PWRITE;
  assign sel      = PADDR[4:2];
  assign a_ctrl   = (sel == 3'd0);
  assign a_pre    = (sel == 3'd1);
  assign a_dir    = (sel == 3'd2);
  assign a_fifo   = (sel == 3'd3);
  assign a_stat   = (sel == 3'd4);
  assign a_cap    = (sel == 3'd5);
  assign unmapped = (sel > 3'd5);

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign busy  = (state_q == S_RUN);

  assign retire = busy & en_q & (timer_q == '0);
  assign pop    = retire & ~loop_q;
  // Looping rotates the head to the tail so the
  // valid window stays contiguous behind wptr.
  assign rot    = retire & loop_q;
  assign flush  = wr & a_ctrl & PWDATA[3];

  assign push_req = wr & a_fifo;
  assign push_ok  = push_req & (~full | pop);

  assign rptr_nx   = rptr_q + AW'(1);
  assign wptr_nx   = wptr_q + AW'(1);
  assign cnt_after = count_q + CW'(push_ok) - CW'(pop);

  // The next head may be the slot being written
  // this very cycle (single-entry window).
  always_comb begin
    nxt_head = mem_q[rptr_nx];
    if (rptr_nx == wptr_q)
      nxt_head = rot ? mem_q[rptr_q] : PWDATA[7:0];
  end

  always_comb begin
    en_d    = en_q;
    loop_d  = loop_q;
    ie_d    = ie_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    done_d  = done_q;
    state_d = state_q;
    timer_d = timer_q;
    out_d   = out_q;
    cap_d   = cap_q;
    wptr_d  = wptr_q + AW'(push_ok) + AW'(rot);
    rptr_d  = rptr_q + AW'(retire);
    count_d = cnt_after;

    if (wr) begin
      unique case (1'b1)
        a_ctrl: begin
          en_d   = PWDATA[0];
          loop_d = PWDATA[1];
          ie_d   = PWDATA[2];
        end
        a_pre:  pre_d = PWDATA[15:0];
        a_dir:  dir_d = PWDATA[7:0];
        a_stat: if (PWDATA[8]) done_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (en_q && !empty) begin
          state_d = S_RUN;
          out_d   = mem_q[rptr_q];
          timer_d = pre_q;
        end
      end
      S_RUN: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          cap_d = upio_in_i;
          if (rot || cnt_after != '0) begin
            out_d   = nxt_head;
            timer_d = pre_q;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!en_q || !done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      out_d   = out_q;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      loop_q  <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      int_q   <= 1'b0;
      pre_q   <= '0;
      timer_q <= '0;
      dir_q   <= '0;
      out_q   <= '0;
      cap_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      loop_q  <= loop_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      int_q   <= done_q & ie_q;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (rot) mem_q[wptr_q] <= mem_q[rptr_q];
      if (push_ok) begin
        if (rot) mem_q[wptr_nx] <= PWDATA[7:0];
        else     mem_q[wptr_q]  <= PWDATA[7:0];
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      unique case (1'b1)
        a_ctrl: PRDATA = {29'd0, ie_q, loop_q, en_q};
        a_pre:  PRDATA = {16'd0, pre_q};
        a_dir:  PRDATA = {24'd0, dir_q};
        a_stat: PRDATA = {23'd0, done_q, busy, full,
                          empty, 5'(count_q)};
        a_cap:  PRDATA = {24'd0, cap_q};
        default: PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = acc & (unmapped | (push_req & ~push_ok));

  assign upio_out_o = out_q;
  assign upio_dir_o = dir_q;
  assign int_o      = int_q;

  assign unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:5],
                       PADDR[1:0], PWDATA[31:16]};

endmodule

// File: tb/tb_up_seq_ctrl.sv
// tb_up_seq_ctrl: scoreboard bench for up_seq_ctrl.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_up_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  pin_in, pin_out, pin_dir;
  logic        irq;

  up_seq_ctrl #(.APB_ADDR_WIDTH(12), .FIFO_DEPTH(8)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel), .PENABLE(penable), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr),
    .upio_in_i(pin_in), .upio_out_o(pin_out),
    .upio_dir_o(pin_dir), .int_o(irq)
  );

  localparam logic [11:0] R_CTRL = 12'h00;
  localparam logic [11:0] R_PRE  = 12'h04;
  localparam logic [11:0] R_DIR  = 12'h08;
  localparam logic [11:0] R_FIFO = 12'h0C;
  localparam logic [11:0] R_STAT = 12'h10;
  localparam logic [11:0] R_CAP  = 12'h14;

  typedef struct {
    bit          pin;
    string       nm;
    logic [31:0] d;
    bit          err;
    bit          chk_d;
    logic [7:0]  out;
    logic        irq;
    logic [7:0]  dir;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   smp = 0;
  bit   fin = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (psel && penable) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL apb_underflow act=empty req=entry");
      end else begin
        me = q.pop_front();
        chk({me.nm, "_kind"}, 32'(me.pin), 32'd0);
        chk({me.nm, "_err"}, 32'(pslverr), 32'(me.err));
        chk({me.nm, "_rdy"}, 32'(pready), 32'd1);
        if (me.chk_d) chk(me.nm, prdata, me.d);
      end
    end
    if (smp) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pin_underflow act=empty req=entry");
      end else begin
        me = q.pop_front();
        chk({me.nm, "_kind"}, 32'(me.pin), 32'd1);
        chk({me.nm, "_out"}, 32'(pin_out), 32'(me.out));
        chk({me.nm, "_int"}, 32'(irq), 32'(me.irq));
        chk({me.nm, "_dir"}, 32'(pin_dir), 32'(me.dir));
      end
    end
    if (fin) chk("drain", 32'(q.size()), 32'd0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apb(input bit w,
                     input logic [11:0] a,
                     input logic [31:0] d,
                     input bit err,
                     input string nm);
    exp_t e;
    psel = 1'b1; penable = 1'b0;
    pwrite = w; paddr = a;
    pwdata = w ? d : 32'd0;
    @(posedge clk); #1;
    e.pin = 1'b0; e.nm = nm; e.d = d;
    e.err = err; e.chk_d = !w;
    e.out = '0; e.irq = 1'b0; e.dir = '0;
    q.push_back(e);
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d,
                    input string nm);
    apb(1'b1, a, d, 1'b0, nm);
  endtask

  task automatic rd(input logic [11:0] a,
                    input logic [31:0] d,
                    input string nm);
    apb(1'b0, a, d, 1'b0, nm);
  endtask

  task automatic pin(input logic [7:0] o,
                     input logic i,
                     input logic [7:0] dr,
                     input string nm);
    exp_t e;
    e.pin = 1'b1; e.nm = nm; e.d = '0;
    e.err = 1'b0; e.chk_d = 1'b0;
    e.out = o; e.irq = i; e.dir = dr;
    q.push_back(e);
    smp = 1'b1;
    @(posedge clk); #1;
    smp = 1'b0;
  endtask

  logic [7:0] seq3 [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    pin_in = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    pin(8'h00, 1'b0, 8'h00, "rst_pins");
    rst_n = 1'b1;
    idle(1);
    rd(R_STAT, 32'h20, "rst_status");
    rd(R_CTRL, 32'h0, "rst_ctrl");

    // three-entry run, PRESCALE=2, IE on
    wr(R_PRE, 32'd2, "wr_pre");
    wr(R_FIFO, 32'h11, "push11");
    wr(R_FIFO, 32'h22, "push22");
    wr(R_FIFO, 32'h33, "push33");
    rd(R_STAT, 32'h03, "cnt3");
    wr(R_DIR, 32'hF0, "wr_dir");
    rd(R_DIR, 32'hF0, "rd_dir");
    apb(1'b0, 12'h18, 32'h0, 1'b1, "unmap_rd");
    apb(1'b1, 12'h1C, 32'hFFFF, 1'b1, "unmap_wr");
    rd(R_STAT, 32'h03, "cnt3_again");
    wr(R_CTRL, 32'h5, "start");
    pin(8'h00, 1'b0, 8'hF0, "latency_hold");
    for (int i = 0; i < 9; i++)
      pin(seq3[i/3], 1'b0, 8'hF0, "seq3");
    rd(R_STAT, 32'h120, "done_status");
    pin(8'h33, 1'b1, 8'hF0, "int_set");
    rd(R_CAP, 32'h5A, "capture");
    rd(R_FIFO, 32'h0, "wo_read");
    wr(R_STAT, 32'h100, "w1c");
    rd(R_STAT, 32'h20, "done_clr");
    pin(8'h33, 1'b0, 8'hF0, "int_clr");
    wr(R_CTRL, 32'h8, "flush0");

    // fill, overflow, then replay the contents
    for (int i = 0; i < 8; i++)
      wr(R_FIFO, 32'(i + 1), "fill");
    apb(1'b1, R_FIFO, 32'h99, 1'b1, "push_full");
    rd(R_STAT, 32'h48, "full_status");
    wr(R_PRE, 32'd0, "pre0");
    wr(R_CTRL, 32'h1, "start2");
    pin(8'h33, 1'b0, 8'hF0, "latency2");
    for (int i = 0; i < 8; i++)
      pin(8'(i + 1), 1'b0, 8'hF0, "replay");
    rd(R_STAT, 32'h120, "done2");
    wr(R_STAT, 32'h100, "w1c2");
    wr(R_CTRL, 32'h8, "flush1");

    // loop mode, then flush mid-run
    wr(R_FIFO, 32'hA0, "pushA0");
    wr(R_FIFO, 32'h0A, "push0A");
    wr(R_CTRL, 32'h3, "start_loop");
    pin(8'h08, 1'b0, 8'hF0, "latency3");
    for (int i = 0; i < 20; i++)
      pin((i % 2) ? 8'h0A : 8'hA0, 1'b0, 8'hF0, "loop");
    rd(R_STAT, 32'h82, "loop_status");
    wr(R_CTRL, 32'h8, "flush_run");
    pin(8'h0A, 1'b0, 8'hF0, "flush_hold");
    rd(R_STAT, 32'h20, "flush_status");
    pin(8'h0A, 1'b0, 8'hF0, "flush_hold2");

    // full FIFO, push on the retire cycle
    for (int i = 0; i < 8; i++)
      wr(R_FIFO, 32'(8'h10 + i), "fill2");
    wr(R_CTRL, 32'h1, "start4");
    wr(R_FIFO, 32'h18, "push_retire");
    rd(R_STAT, 32'h87, "retire_cnt");
    idle(10);
    pin(8'h18, 1'b0, 8'hF0, "pushed_ran");
    rd(R_STAT, 32'h120, "done4");
    wr(R_STAT, 32'h100, "w1c4");
    wr(R_CTRL, 32'h8, "flush4");

    // reset in the middle of a run
    wr(R_PRE, 32'd3, "pre3");
    wr(R_FIFO, 32'h55, "push55");
    wr(R_FIFO, 32'h66, "push66");
    wr(R_CTRL, 32'h5, "start5");
    pin(8'h18, 1'b0, 8'hF0, "latency5");
    pin(8'h55, 1'b0, 8'hF0, "run55");
    #2;
    rst_n = 1'b0;
    pin(8'h00, 1'b0, 8'h00, "async_rst");
    rst_n = 1'b1;
    idle(1);
    rd(R_STAT, 32'h20, "post_rst_status");
    rd(R_DIR, 32'h0, "post_rst_dir");
    rd(R_PRE, 32'h0, "post_rst_pre");
    rd(R_CTRL, 32'h0, "post_rst_ctrl");
    pin(8'h00, 1'b0, 8'h00, "post_rst_pins");

    fin = 1'b1;
    @(posedge clk); #1;
    fin = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/up_seq_ctrl.md
UP_SEQ_CTRL -- requirements
Module: up_seq_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, the width of the decoded APB address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the number of pattern entries (power of 2, 2..16).
REQ-003 SHALL have port HCLK, input, 1 bit, the single block clock.
REQ-004 SHALL have port HRESETn, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 SHALL have APB slave ports: PADDR (in, APB_ADDR_WIDTH), PWDATA (in, 32), PWRITE (in, 1), PSEL (in, 1), PENABLE (in, 1), PRDATA (out, 32), PREADY (out, 1), PSLVERR (out, 1).
REQ-006 SHALL have port upio_in_i, input, 8 bits, the pad input values.
REQ-007 SHALL have port upio_out_o, output, 8 bits, the sequenced pad output pattern.
REQ-008 SHALL have port upio_dir_o, output, 8 bits, the pad direction (1 = output).
REQ-009 SHALL have port int_o, output, 1 bit, the level interrupt.

Function
REQ-010 SHALL keep PREADY at 1; an access SHALL occur in the cycle where PSEL=1 and PENABLE=1, with address bits [4:2] decoded.
REQ-011 SHALL implement this register map: 0x00 CTRL (bit0 EN, bit1 LOOP, bit2 IE, bit3 FLUSH; FLUSH is write-only and self-clearing); 0x04 PRESCALE [15:0]; 0x08 DIR [7:0] driving upio_dir_o; 0x0C FIFO (write-only, push of PWDATA[7:0]); 0x10 STATUS (see REQ-012); 0x14 CAPTURE [7:0] (read-only).
REQ-012 SHALL provide STATUS as: [4:0] count, bit5 empty, bit6 full, bit7 busy (state RUN), bit8 DONE (sticky, write-1-to-clear); all other bits SHALL read 0.
REQ-013 SHALL assert PSLVERR for one cycle, with no state change, on a FIFO write when full or an access to an unmapped address; reads of write-only or unmapped locations SHALL return 0.
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, when EN=1 and count>0, the FSM SHALL go to RUN; on that edge upio_out_o SHALL load the FIFO head and the timer SHALL load PRESCALE.
REQ-016 In RUN, the timer SHALL decrement each cycle, so each pattern is held exactly PRESCALE+1 cycles (PRESCALE=0 gives 1 cycle).
REQ-017 At timer=0, CAPTURE SHALL sample upio_in_i and the current entry SHALL retire.
REQ-018 When an entry retires with LOOP=0, the entry SHALL be popped (count-1); then, if count is still >0, the next entry SHALL load with the timer reloaded, otherwise the FSM SHALL go to DONE.
REQ-019 When an entry retires with LOOP=1, the read pointer SHALL advance and wrap over the valid entries, count SHALL be unchanged, and DONE SHALL never be reached.
REQ-020 On entry to DONE, the DONE flag SHALL be set.
REQ-021 The FSM SHALL leave DONE for IDLE in the cycle after DONE is cleared; if EN=1 and count>0 it SHALL then restart per REQ-015.
REQ-022 In any state, EN=0 SHALL send the FSM to IDLE on the next edge, with upio_out_o holding its last value and FIFO contents kept.
REQ-023 FLUSH SHALL zero count and both pointers and send the FSM to IDLE; FLUSH takes priority over a same-cycle push.
REQ-024 A push coinciding with a pop SHALL leave count unchanged and SHALL be accepted even when the FIFO is full.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 int_o SHALL equal DONE AND IE, registered.
REQ-027 Latency: upio_out_o SHALL change 2 cycles after the APB access cycle that sets EN (register update, then FSM edge).

Reset
REQ-028 On HRESETn low, the block SHALL immediately set all registers to 0, set the FSM to IDLE, set count and pointers to 0, and drive upio_out_o=0x00, upio_dir_o=0x00, PRDATA=0, PSLVERR=0 and int_o=0.
REQ-029 Reset asserted mid-RUN SHALL abort the sequence with no retained state.

Verification
REQ-030 Push 0x11,0x22,0x33, PRESCALE=2, write CTRL=0x5 -> upio_out_o shows 0x11,0x22,0x33 for 3 cycles each, then DONE=1, int_o=1, count=0.
REQ-031 Push 8 entries, then a 9th write -> PSLVERR=1, STATUS full=1, count=8, contents unchanged.
REQ-032 LOOP=1, entries 0xA0,0x0A, PRESCALE=0 -> upio_out_o alternates every cycle for 20 cycles, count stays 2, DONE stays 0.
REQ-033 Mid-RUN write CTRL=0x8 (FLUSH) -> next cycle busy=0, count=0, upio_out_o holds its value.
REQ-034 Full FIFO, run with PRESCALE=0, push at the retire cycle -> accepted, no PSLVERR, count stays 8.
REQ-035 Assert HRESETn low mid-RUN -> all outputs 0 asynchronously; after release STATUS reads 0x20.
